// File: rtl/rv_alu_pkg.sv
// Shared ALU control codes, mul/div op encodings and sequencer state type.
package rv_alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  typedef enum logic [1:0] {
    MD_MUL  = 2'b00,
    MD_DIVU = 2'b01,
    MD_REMU = 2'b10,
    MD_ILL  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } md_state_e;

endpackage

// File: rtl/alu_unit.sv
// Combinational integer ALU (AND/OR/ADD/SUB), zero latency, no flow control.
// Operands are raw bits; unknown control codes produce zero.
module alu_unit
  import rv_alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic [3:0]      control_i,
  output logic [XLEN-1:0] result_o,
  output logic            zero_o
);

  always_comb begin
    result_o = '0;
    case (control_i)
      ALU_AND: result_o = a_i & b_i;
      ALU_OR:  result_o = a_i | b_i;
      ALU_ADD: result_o = a_i + b_i;
      ALU_SUB: result_o = a_i - b_i;
      default: result_o = '0;
    endcase
  end

  assign zero_o = (result_o == '0);

endmodule

// File: rtl/muldiv_sequencer.sv
// Bit-serial MUL / DIVU / REMU: XLEN+1 cycles per op (1 for special cases), one op at a time.
// stall_o holds the pipeline from request until the done_o cycle; flush_i aborts silently.
module muldiv_sequencer
  import rv_alu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic            err_o
);

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);

  md_state_e        state_q, state_d;
  md_op_e           op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // acc: product accumulator (MUL) or partial remainder (DIV/REM)
  // x:   multiplicand (MUL) or dividend shifting into quotient (DIV/REM)
  // y:   multiplier (MUL) or divisor (DIV/REM)
  logic [XLEN-1:0]  acc_q, acc_d;
  logic [XLEN-1:0]  x_q, x_d;
  logic [XLEN-1:0]  y_q, y_d;

  logic             is_mul;
  logic [XLEN:0]    rem_sh;
  logic             take;
  logic [XLEN-1:0]  alu_a, alu_b, alu_res;
  logic [3:0]       alu_ctrl;
  logic             alu_zero_unused;

  assign is_mul   = (op_q == MD_MUL);
  assign rem_sh   = {acc_q, x_q[XLEN-1]};
  assign take     = rem_sh[XLEN] | (rem_sh[XLEN-1:0] >= y_q);
  assign alu_a    = is_mul ? acc_q : rem_sh[XLEN-1:0];
  assign alu_b    = is_mul ? x_q : y_q;
  assign alu_ctrl = is_mul ? ALU_ADD : ALU_SUB;

  alu_unit #(.XLEN(XLEN)) u_alu (
    .a_i       (alu_a),
    .b_i       (alu_b),
    .control_i (alu_ctrl),
    .result_o  (alu_res),
    .zero_o    (alu_zero_unused)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    x_d     = x_q;
    y_d     = y_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i && !flush_i) begin
          op_d    = md_op_e'(op_i);
          cnt_d   = '0;
          acc_d   = '0;
          x_d     = a_i;
          y_d     = b_i;
          state_d = ST_RUN;
          // Results that need no iteration are preloaded where DONE will read them.
          case (md_op_e'(op_i))
            MD_ILL: begin
              x_d     = '0;
              state_d = ST_DONE;
            end
            MD_DIVU: if (b_i == '0) begin
              x_d     = '1;
              state_d = ST_DONE;
            end
            MD_REMU: if (b_i == '0) begin
              acc_d   = a_i;
              state_d = ST_DONE;
            end
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        if (flush_i) begin
          state_d = ST_IDLE;
        end else begin
          if (is_mul) begin
            acc_d = y_q[0] ? alu_res : acc_q;
            x_d   = x_q << 1;
            y_d   = y_q >> 1;
          end else begin
            acc_d = take ? alu_res : rem_sh[XLEN-1:0];
            x_d   = {x_q[XLEN-2:0], take};
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_STEP) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= MD_MUL;
      cnt_q   <= '0;
      acc_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  assign stall_o = ((state_q == ST_IDLE) && start_i && !flush_i) || (state_q == ST_RUN);
  assign done_o  = (state_q == ST_DONE) && !flush_i;
  assign err_o   = done_o && (op_q == MD_ILL);

  always_comb begin
    result_o = '0;
    if (done_o) begin
      case (op_q)
        MD_MUL:  result_o = acc_q;
        MD_DIVU: result_o = x_q;
        MD_REMU: result_o = acc_q;
        default: result_o = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: directed corner cases plus random ops vs arithmetic model.
module tb_muldiv_sequencer;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start_i;
  logic [1:0]      op_i;
  logic [XLEN-1:0] a_i;
  logic [XLEN-1:0] b_i;
  logic            flush_i;
  logic            stall_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;
  logic            err_o;

  typedef struct {
    logic [31:0] res;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc     = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  muldiv_sequencer #(.XLEN(32), .CNT_W(6)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start_i),
    .op_i     (op_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .flush_i  (flush_i),
    .stall_o  (stall_o),
    .done_o   (done_o),
    .result_o (result_o),
    .err_o    (err_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] p;
    case (op)
      2'b00: begin
        p = 64'(a) * 64'(b);
        return p[31:0];
      end
      2'b01: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      2'b10: return (b == 0) ? a : a % b;
      default: return 32'h0;
    endcase
  endfunction

  // Monitor: every done_o pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (rst_n && done_o) begin
      if (sb.size() == 0) begin
        check("done_outstanding", sb.size(), 1);
      end else begin
        e = sb.pop_front();
        check("result", result_o, e.res);
        check("err", {31'b0, err_o}, {31'b0, e.err});
        check("done_cycle", cyc, e.cyc);
        check("stall_in_done", {31'b0, stall_o}, 32'h0);
      end
    end
  end

  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   stalls = 0;
    int   waited = 0;
    bit   special;
    @(negedge clk);
    start_i = 1'b1;
    op_i    = op;
    a_i     = a;
    b_i     = b;
    special = (op == 2'b11) || (op != 2'b00 && b == 0);
    e.res   = model(op, a, b);
    e.err   = (op == 2'b11);
    e.cyc   = cyc + 1 + (special ? 0 : XLEN);
    sb.push_back(e);
    #1;
    while (!done_o && waited < 200) begin
      if (stall_o) stalls++;
      @(negedge clk);
      #1;
      waited++;
    end
    check("done_seen", {31'b0, done_o}, 32'h1);
    check("stall_cycles", stalls, special ? 1 : XLEN + 1);
    start_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    rst_n   = 1'b0;
    start_i = 1'b0;
    flush_i = 1'b0;
    op_i    = 2'b00;
    a_i     = '0;
    b_i     = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_stall", {31'b0, stall_o}, 32'h0);
    check("rst_done", {31'b0, done_o}, 32'h0);
    check("rst_err", {31'b0, err_o}, 32'h0);
    check("rst_result", result_o, 32'h0);
    rst_n = 1'b1;

    do_op(2'b00, 32'd7, 32'd6);
    do_op(2'b00, 32'hFFFF_FFFF, 32'd2);
    do_op(2'b01, 32'd100, 32'd7);
    do_op(2'b10, 32'd100, 32'd7);
    do_op(2'b01, 32'hFFFF_FFFF, 32'h8000_0001);
    do_op(2'b10, 32'hFFFF_FFFF, 32'h8000_0001);
    do_op(2'b01, 32'd1234, 32'd0);
    do_op(2'b10, 32'd5, 32'd0);
    do_op(2'b11, 32'd123, 32'd456);
    do_op(2'b00, 32'd0, 32'hDEAD_BEEF);

    // Flush at RUN step 10: op vanishes without done_o.
    @(negedge clk);
    start_i = 1'b1; op_i = 2'b00; a_i = 32'd123; b_i = 32'd456;
    repeat (11) @(negedge clk);
    flush_i = 1'b1; start_i = 1'b0;
    #1;
    check("stall_run_before_flush", {31'b0, stall_o}, 32'h1);
    @(negedge clk);
    flush_i = 1'b0;
    #1;
    check("stall_after_flush", {31'b0, stall_o}, 32'h0);
    check("done_after_flush", {31'b0, done_o}, 32'h0);
    repeat (40) @(negedge clk);
    do_op(2'b00, 32'd3, 32'd3);

    // Flush wins over start in IDLE.
    @(negedge clk);
    start_i = 1'b1; flush_i = 1'b1; op_i = 2'b00; a_i = 32'd9; b_i = 32'd9;
    #1;
    check("stall_flush_idle", {31'b0, stall_o}, 32'h0);
    @(negedge clk);
    start_i = 1'b0; flush_i = 1'b0;
    #1;
    check("stall_not_started", {31'b0, stall_o}, 32'h0);

    // Asynchronous reset mid-RUN.
    @(negedge clk);
    start_i = 1'b1; op_i = 2'b01; a_i = 32'd1000; b_i = 32'd3;
    repeat (6) @(negedge clk);
    #2;
    rst_n = 1'b0; start_i = 1'b0;
    #1;
    check("midrst_stall", {31'b0, stall_o}, 32'h0);
    check("midrst_done", {31'b0, done_o}, 32'h0);
    check("midrst_err", {31'b0, err_o}, 32'h0);
    check("midrst_result", result_o, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 25; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 500));
      case ($urandom_range(0, 3))
        0:       rb = 32'h0;
        1:       rb = 32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      do_op(rop, ra, rb);
    end

    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
